fmul_arbiter: RTL

- Round-robin scheduler that shares one single-precision multiplier instance (combinational a/b -> z plus NAN/zero/underflow/overflow flags) among NUM_REQ requesters.
- Accepts one operand pair at a time over per-requester valid/ready, registers the operands onto the multiplier inputs, waits MUL_LAT cycles, then captures the result and returns it with the requester ID over a single response valid/ready channel.
- Sits between the FP issue logic and the multiplier datapath.

---
 rtl/fmul_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/fmul_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared types and constants for the fmul_arbiter multiplier scheduler.
package fmul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit positions inside the 4-bit flag vector {NAN, zero, underflow, overflow}
  localparam int FLAG_NAN = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 0;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr+1, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] slot;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 1; k <= N; k++) begin
      slot = IW'((int'(ptr) + k) % N);
      if (!found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        idx         = slot;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin scheduler sharing one FP multiplier among NUM_REQ requesters.
// Optional flag capture is built when FMUL_ARB_FLAGS_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and resp_* holds stable while
// resp_valid is high and resp_ready is low.
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int MUL_LAT = 1,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_z,
  input  logic [3:0]            mul_flags,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [31:0]           resp_z,
`ifdef FMUL_ARB_FLAGS_EN
  output logic [3:0]            resp_flags,
`endif
  output state_t                dbg_state
);

  localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 1);

  state_t               state, state_next;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [3:0]           lat_cnt;
  logic                 accept;
  logic                 calc_done;
  logic                 resp_done;

  rr_pick #(
    .N (NUM_REQ),
    .IW(IDW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (grant_idx)
  );

  // Grant is recomputed every IDLE cycle; nothing is latched before the handshake.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign calc_done = (state == CALC) && (lat_cnt == 4'd0);
  assign resp_done = (state == RESP) && resp_ready;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (calc_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= IDW'(NUM_REQ - 1);
      mul_a      <= '0;
      mul_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_z     <= '0;
      lat_cnt    <= '0;
    end else begin
      if (accept) begin
        mul_a   <= req_a[{grant_idx, 5'd0} +: 32];
        mul_b   <= req_b[{grant_idx, 5'd0} +: 32];
        resp_id <= grant_idx;
        rr_ptr  <= grant_idx;
        lat_cnt <= LAT_LOAD;
      end
      if (state == CALC) begin
        if (calc_done) begin
          resp_z     <= mul_z;
          resp_valid <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
      end
      if (resp_done) resp_valid <= 1'b0;
    end
  end

`ifdef FMUL_ARB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         resp_flags <= '0;
    else if (calc_done) resp_flags <= mul_flags;
  end
`else
  logic unused_flags;
  assign unused_flags = ^mul_flags;
`endif

endmodule
